// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds the architectural V/Z/N flags and evaluates the
// 8 conditional-branch codes at EX. A taken branch raises a registered PC
// redirect toward fetch and holds flush/stall until the redirect is accepted
// and the younger slots have drained.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flg_we[2:0]                 per-flag write enables {V,Z,N}
//   alu_V, alu_Z, alu_N         flag values from the ALU
//   br_valid, br_cond, br_target  branch in EX, condition code, taken target
//   redir_ready                 fetch accepts the redirect
//   redir_valid, redir_pc       registered redirect request and address
//   flush, stall                kill / hold younger pipeline slots
//   flags_q[2:0]                registered {V,Z,N}
//   br_count, taken_count       saturating statistics (BRANCH_STATS_EN only)
//
// Optional feature macro: BRANCH_STATS_EN.

module branch_resolve_unit #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      flg_we,
  input  logic            alu_V,
  input  logic            alu_Z,
  input  logic            alu_N,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            redir_ready,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic            flush,
  output logic            stall,
  output logic [2:0]      flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     br_count,
  output logic [15:0]     taken_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIRECT,
    S_DRAIN
  } state_t;

  localparam logic [2:0] LP_FC = 3'(FLUSH_CYCLES);

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic [2:0]      r_flags;
  logic            r_redir_valid;
  logic [PC_W-1:0] r_redir_pc;
  logic            r_flush;
  logic            r_stall;

  logic [2:0]      w_eff;
  logic            w_v;
  logic            w_z;
  logic            w_n;
  logic            w_take;

  // A flag writer in the same cycle is older than the branch, so bypass it.
  assign w_eff = (flg_we & {alu_V, alu_Z, alu_N})
               | (~flg_we & r_flags);
  assign w_v = w_eff[2];
  assign w_z = w_eff[1];
  assign w_n = w_eff[0];

  always_comb begin
    w_take = 1'b0;
    unique case (br_cond)
      3'b000: w_take = !w_z;
      3'b001: w_take = w_z;
      3'b010: w_take = !w_z && !w_n;
      3'b011: w_take = w_n;
      3'b100: w_take = w_z || (!w_z && !w_n);
      3'b101: w_take = w_n || w_z;
      3'b110: w_take = w_v;
      3'b111: w_take = 1'b1;
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else begin
      r_flags <= w_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_flush       <= 1'b0;
      r_stall       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (br_valid && w_take) begin
            r_redir_valid <= 1'b1;
            r_redir_pc    <= br_target;
            r_flush       <= 1'b1;
            r_stall       <= 1'b1;
            r_state       <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redir_ready) begin
            r_redir_valid <= 1'b0;
            if (LP_FC == 3'd0) begin
              r_flush <= 1'b0;
              r_stall <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= LP_FC;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt <= 3'd1) begin
            r_cnt   <= 3'd0;
            r_flush <= 1'b0;
            r_stall <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic        w_accept;
  logic [15:0] r_br_count;
  logic [15:0] r_taken_count;

  assign w_accept = (r_state == S_IDLE) && br_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count    <= 16'd0;
      r_taken_count <= 16'd0;
    end else begin
      if (w_accept && r_br_count != 16'hFFFF) begin
        r_br_count <= r_br_count + 16'd1;
      end
      if (w_accept && w_take && r_taken_count != 16'hFFFF) begin
        r_taken_count <= r_taken_count + 16'd1;
      end
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
`endif

  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;
  assign flush       = r_flush;
  assign stall       = r_stall;
  assign flags_q     = r_flags;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a redirect scoreboard.
// Expected redirect targets are queued at issue and checked at handshake.

module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  flg_we;
  logic        alu_V;
  logic        alu_Z;
  logic        alu_N;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic        redir_ready;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        flush;
  logic        stall;
  logic [2:0]  flags_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_count;
  logic [15:0] taken_count;
`endif

  int nasrt = 0;
  int nfail = 0;
  int exp_br = 0;
  int exp_tk = 0;
  logic [15:0] sb_q[$];

  branch_resolve_unit #(
    .PC_W(16),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flg_we(flg_we),
    .alu_V(alu_V),
    .alu_Z(alu_Z),
    .alu_N(alu_N),
    .br_valid(br_valid),
    .br_cond(br_cond),
    .br_target(br_target),
    .redir_ready(redir_ready),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .flush(flush),
    .stall(stall),
    .flags_q(flags_q)
`ifdef BRANCH_STATS_EN
    ,
    .br_count(br_count),
    .taken_count(taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_taken(input logic [2:0] c,
                                     input logic v,
                                     input logic z,
                                     input logic n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Run n cycles, counting redirect and flush cycles; pop the scoreboard
  // whenever a handshake is about to complete on the next edge.
  task automatic run_cycles(input int n,
                            output int vcyc,
                            output int fcyc);
    vcyc = 0;
    fcyc = 0;
    for (int i = 0; i < n; i++) begin
      if (redir_valid) vcyc++;
      if (flush) fcyc++;
      if (redir_valid && redir_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'(redir_pc), 32'hFFFF_FFFF);
        end else begin
          chk("sb_pc", 32'(redir_pc), 32'(sb_q.pop_front()));
        end
      end
      tick();
    end
  endtask

  // Drive a branch in IDLE for one edge; queue its target if taken.
  task automatic issue(input logic [2:0] c,
                       input logic [15:0] tgt,
                       input logic tk);
    br_valid  = 1'b1;
    br_cond   = c;
    br_target = tgt;
    exp_br++;
    if (tk) begin
      exp_tk++;
      sb_q.push_back(tgt);
    end
    tick();
    br_valid = 1'b0;
    flg_we   = 3'b000;
  endtask

  initial begin
    int vc;
    int fc;
    logic [2:0] fl;
    logic tk;

    rst_n       = 1'b0;
    flg_we      = 3'b000;
    alu_V       = 1'b0;
    alu_Z       = 1'b0;
    alu_N       = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'b000;
    br_target   = 16'h0000;
    redir_ready = 1'b0;

    #12;
    chk("rst_valid", 32'(redir_valid), 32'd0);
    chk("rst_pc", 32'(redir_pc), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Flag register writes
    flg_we = 3'b111;
    alu_V  = 1'b0;
    alu_Z  = 1'b1;
    alu_N  = 1'b0;
    tick();
    chk("flags_add", 32'(flags_q), 32'b010);
    flg_we = 3'b010;
    alu_Z  = 1'b0;
    alu_N  = 1'b1;
    tick();
    chk("flags_logic", 32'(flags_q), 32'b000);
    alu_Z = 1'b1;
    tick();
    flg_we = 3'b000;
    chk("flags_z", 32'(flags_q), 32'b010);

    // Taken EQ from registered Z with ready held
    redir_ready = 1'b1;
    issue(3'b001, 16'h0040, 1'b1);
    chk("eq_valid", 32'(redir_valid), 32'd1);
    chk("eq_pc", 32'(redir_pc), 32'h0040);
    chk("eq_stall", 32'(stall), 32'd1);
    run_cycles(6, vc, fc);
    chk("eq_vcyc", 32'(vc), 32'd1);
    chk("eq_fcyc", 32'(fc), 32'd3);
    chk("eq_idle_flush", 32'(flush), 32'd0);
    chk("eq_idle_stall", 32'(stall), 32'd0);

    // Same-cycle writer clears Z: bypass makes EQ not taken
    flg_we = 3'b111;
    alu_V  = 1'b0;
    alu_Z  = 1'b0;
    alu_N  = 1'b0;
    issue(3'b001, 16'h0080, 1'b0);
    run_cycles(3, vc, fc);
    chk("byp_vcyc", 32'(vc), 32'd0);
    chk("byp_fcyc", 32'(fc), 32'd0);
    chk("byp_flags", 32'(flags_q), 32'b000);

    // All condition codes against several flag patterns via bypass
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: fl = 3'b010;
        1: fl = 3'b001;
        2: fl = 3'b100;
        default: fl = 3'b000;
      endcase
      for (int c = 0; c < 8; c++) begin
        flg_we = 3'b111;
        alu_V  = fl[2];
        alu_Z  = fl[1];
        alu_N  = fl[0];
        tk = exp_taken(3'(c), fl[2], fl[1], fl[0]);
        issue(3'(c), 16'(16'h0100 + 16 * p + c), tk);
        run_cycles(5, vc, fc);
        chk($sformatf("cond%0d_p%0d", c, p), 32'(vc), 32'(tk));
      end
    end

    // Registered-flag path (no bypass): flags_q = 000 now, LT not taken
    issue(3'b011, 16'h0200, 1'b0);
    run_cycles(3, vc, fc);
    chk("reg_lt_vcyc", 32'(vc), 32'd0);

    // UNCOND with fetch back-pressure; extra branch must be ignored
    redir_ready = 1'b0;
    issue(3'b111, 16'h1234, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(redir_valid), 32'd1);
      chk($sformatf("bp_pc%0d", i), 32'(redir_pc), 32'h1234);
      chk($sformatf("bp_flush%0d", i), 32'(flush & stall), 32'd1);
      br_valid  = (i == 1);
      br_cond   = 3'b111;
      br_target = 16'hBEEF;
      tick();
      br_valid = 1'b0;
    end
    redir_ready = 1'b1;
    run_cycles(8, vc, fc);
    chk("bp_vcyc", 32'(vc), 32'd1);
    chk("bp_fcyc", 32'(fc), 32'd3);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while draining
    flg_we = 3'b111;
    alu_V  = 1'b1;
    alu_Z  = 1'b1;
    alu_N  = 1'b1;
    issue(3'b111, 16'h0ABC, 1'b1);
    chk("rd_valid", 32'(redir_valid), 32'd1);
    chk("rd_pc", 32'(redir_pc), 32'(sb_q.pop_front()));
    tick();
    chk("rd_drain_flush", 32'(flush), 32'd1);
    chk("rd_drain_valid", 32'(redir_valid), 32'd0);
    chk("rd_flags_pre", 32'(flags_q), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_valid0", 32'(redir_valid), 32'd0);
    chk("rd_flush0", 32'(flush), 32'd0);
    chk("rd_stall0", 32'(stall), 32'd0);
    chk("rd_flags0", 32'(flags_q), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rd_brcnt0", 32'(br_count), 32'd0);
    chk("rd_tkcnt0", 32'(taken_count), 32'd0);
    exp_br = 0;
    exp_tk = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Post-reset: a branch works normally again
    issue(3'b111, 16'h00F0, 1'b1);
    issue_check_tail: begin
      run_cycles(6, vc, fc);
      chk("post_vcyc", 32'(vc), 32'd1);
      chk("post_fcyc", 32'(fc), 32'd3);
    end
    issue(3'b110, 16'h00F4, 1'b0);
    run_cycles(2, vc, fc);
    chk("post_nt_vcyc", 32'(vc), 32'd0);

`ifdef BRANCH_STATS_EN
    chk("stats_br", 32'(br_count), 32'(exp_br));
    chk("stats_tk", 32'(taken_count), 32'(exp_tk));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
